// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready handshake; shifts iterate one bit per cycle.
// Define ALU_SEQ_FAST_SHIFT_EN for a single-cycle barrel shifter instead.
module alu_seq_exec #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            operation,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero,
   output logic                  branch_taken
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_XOR  = 4'b0001;
   localparam logic [3:0] OP_ADDM = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_BGE  = 4'b0101;
   localparam logic [3:0] OP_BNE  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_LUI  = 4'b1010;
   localparam logic [3:0] OP_SUB  = 4'b1011;
   localparam logic [3:0] OP_SRL  = 4'b1100;
   localparam logic [3:0] OP_BLT  = 4'b1101;
   localparam logic [3:0] OP_SLT  = 4'b1110;

`ifdef ALU_SEQ_FAST_SHIFT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   result_d;
   logic                    zero_d;
   logic                    taken_d;

   logic [SHAMT_WIDTH-1:0]  shamt;
   logic [DATA_WIDTH-1:0]   diff;
   logic                    lt_s;
   logic [DATA_WIDTH-1:0]   alu_res;
   logic                    alu_taken;

   assign shamt = op_b[SHAMT_WIDTH-1:0];
   assign diff  = op_a - op_b;
   assign lt_s  = $signed(op_a) < $signed(op_b);

   // Single-cycle result for the captured operation
   always_comb begin
      alu_res   = '0;
      alu_taken = 1'b0;
      unique case (operation)
         OP_AND:          alu_res = op_a & op_b;
         OP_XOR:          alu_res = op_a ^ op_b;
         OP_OR:           alu_res = op_a | op_b;
         OP_ADDM, OP_ADD: alu_res = op_a + op_b;
         OP_SUB:          alu_res = diff;
         OP_LUI:          alu_res = op_b;
         OP_SLT:          alu_res = DATA_WIDTH'(lt_s);
`ifdef ALU_SEQ_FAST_SHIFT_EN
         OP_SLL:          alu_res = op_a << shamt;
         OP_SRL:          alu_res = op_a >> shamt;
         OP_SRA:          alu_res = DATA_WIDTH'($signed(op_a) >>> shamt);
`else
         // only reached with shamt == 0; nonzero amounts go through SHIFT
         OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
`endif
         OP_BEQ: begin alu_res = diff; alu_taken = (op_a == op_b); end
         OP_BNE: begin alu_res = diff; alu_taken = (op_a != op_b); end
         OP_BLT: begin alu_res = diff; alu_taken = lt_s;           end
         OP_BGE: begin alu_res = diff; alu_taken = !lt_s;          end
         default: begin alu_res = '0; alu_taken = 1'b0; end
      endcase
   end

`ifndef ALU_SEQ_FAST_SHIFT_EN
   logic [DATA_WIDTH-1:0]  work_q, work_d, work_step;
   logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
   logic [3:0]             kind_q, kind_d;
   logic                   is_shift;

   assign is_shift = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);

   // One-bit shift of the working register
   always_comb begin
      unique case (kind_q)
         OP_SLL:  work_step = {work_q[DATA_WIDTH-2:0], 1'b0};
         OP_SRA:  work_step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
         default: work_step = {1'b0, work_q[DATA_WIDTH-1:1]};
      endcase
   end
`endif

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      result_d = result;
      zero_d   = zero;
      taken_d  = branch_taken;
`ifndef ALU_SEQ_FAST_SHIFT_EN
      work_d   = work_q;
      cnt_d    = cnt_q;
      kind_d   = kind_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
               if (is_shift && (shamt != '0)) begin
                  work_d  = op_a;
                  cnt_d   = shamt;
                  kind_d  = operation;
                  state_d = SHIFT;
               end else
`endif
               begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  taken_d  = alu_taken;
                  state_d  = DONE;
               end
            end
         end
`ifndef ALU_SEQ_FAST_SHIFT_EN
         SHIFT: begin
            work_d = work_step;
            cnt_d  = cnt_q - SHAMT_WIDTH'(1);
            if (cnt_q == SHAMT_WIDTH'(1)) begin
               result_d = work_step;
               zero_d   = (work_step == '0);
               taken_d  = 1'b0;
               state_d  = DONE;
            end
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         result       <= '0;
         zero         <= 1'b1;
         branch_taken <= 1'b0;
         out_valid    <= 1'b0;
         in_ready     <= 1'b1;
`ifndef ALU_SEQ_FAST_SHIFT_EN
         work_q       <= '0;
         cnt_q        <= '0;
         kind_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         result       <= result_d;
         zero         <= zero_d;
         branch_taken <= taken_d;
         out_valid    <= (state_d == DONE);
         in_ready     <= (state_d == IDLE);
`ifndef ALU_SEQ_FAST_SHIFT_EN
         work_q       <= work_d;
         cnt_q        <= cnt_d;
         kind_q       <= kind_d;
`endif
      end
   end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU directly downstream of the ALU operation decoder.
- Consumes the 4-bit Operation code plus two operands and produces the result, a zero flag and a branch-taken flag.
- Shifts run iteratively, one bit per cycle (area-minimal build); all other ops complete in one cycle.
- Valid/ready handshake on both sides so the surrounding multi-cycle datapath can stall it.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from op_b[SHAMT_WIDTH-1:0]; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  operation/operands valid.
- in_ready  output  1  block can accept; equals (state==IDLE).
- operation  input  4  ALU operation code from decoder.
- op_a  input  DATA_WIDTH  operand A.
- op_b  input  DATA_WIDTH  operand B / shift amount.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts result.
- result  output  DATA_WIDTH  registered result.
- zero  output  1  registered (result==0).
- branch_taken  output  1  registered branch decision; 0 for non-branch codes.

Behaviour:
- Reset (asynchronous, active-high; async assert, sync release): state=IDLE, result=0, zero=1, branch_taken=0, out_valid=0, shift counter=0. in_ready=1 once in IDLE. Reset mid-operation discards the operation with no output.
- Operation codes (all others: result=0, branch_taken=0; no error):
  - 0000 AND, 0001 XOR, 0011 OR.
  - 0010 ADD (load/store address), 0100 ADD.
  - 1011 SUB (A-B).
  - 1010 pass B (LUI).
  - 1110 SLT: signed A<B gives 1, else 0.
  - 1001 SLL, 1100 SRL, 0111 SRA.
  - Branch codes: 1000 BEQ, 0110 BNE, 1101 BLT (signed), 0101 BGE (signed). Result=A-B; branch_taken is the comparison outcome.
- Arithmetic: wrap modulo 2^DATA_WIDTH, no overflow flag. Shift amount is op_b[SHAMT_WIDTH-1:0] only; upper bits are ignored.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. When in_valid is high, capture operation/operands.
    - Non-shift op, or shift with shamt=0: compute result and go to DONE.
    - Shift with shamt>0: load working register with A, counter=shamt, go to SHIFT.
  - SHIFT: each cycle shift the working register by 1 (SLL: zero-fill LSB; SRL: zero-fill MSB; SRA: replicate MSB) and decrement the counter. The shift in which the counter reaches 0 moves to DONE with result = working register.
  - DONE: out_valid=1; result/zero/branch_taken held stable. When out_ready is high, go to IDLE with out_valid=0. in_ready=0 in DONE, even when out_ready is high.
- Latency, accept edge to out_valid high:
  - 1 cycle for non-shift ops and shamt=0.
  - 1+shamt cycles for iterative shifts (maximum 32 for DATA_WIDTH=32).
- Throughput: at most one op per 2 cycles.
- Inputs are ignored while in_ready=0. Operands may change after acceptance without affecting the result.
- out_ready asserted while out_valid=0 has no effect.
- zero is always computed from the final result value.

Optional Feature:
- ALU_SEQ_FAST_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter and the SHIFT state is not instantiated; all ops have latency 1.
- Undefined: iterative 1-bit-per-cycle shifter exactly as described in Behaviour.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset mid-SHIFT: reset during SLL of shamt=20 -> out_valid=0, result=0, zero=1, in_ready=1 next cycle; subsequent op runs normally.
- ADD 0100, A=0xFFFFFFFF, B=1 -> result=0, zero=1, out_valid one cycle after accept. SUB 1011, A=5, B=7 -> 0xFFFFFFFE.
- SRA 0111, A=0x80000000, B=0x00000104 (shamt=4) -> result=0xF8000000 exactly 5 cycles after accept. SRL same operands -> 0x08000000. SLL shamt=0 -> result=A, latency 1.
- Branches: BLT A=0xFFFFFFFF, B=1 -> branch_taken=1. BGE same operands -> 0. BEQ A=B=0x1234 -> taken=1, zero=1. BNE same operands -> 0.
- Backpressure: out_ready held 0 for 10 cycles after SLT (A=-3, B=2) -> result=1 held stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle.
- Unknown code 1111, A=B=0xAAAA -> result=0, branch_taken=0, zero=1. With ALU_SEQ_FAST_SHIFT_EN defined, the SRA case completes in 1 cycle with the same value.
